wrr_arbiter: RTL and testbench

- Weighted round-robin arbiter. Shares one resource among CLIENTS requesters.
- The granted client holds the resource for up to its programmed weight in consecutive cycles, then the grant rotates.
- Sits in front of the shared datapath in place of a plain round-robin arbiter, where clients need unequal bandwidth shares. Supports a global stall.

---
 rtl/wrr_pkg.sv | 18 +
 rtl/rr_pick.sv | 33 +++
 rtl/wrr_arbiter.sv | 82 ++++++++
 tb/tb_wrr_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter family.
package wrr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Index width that stays at least one bit wide even for tiny client counts.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned weight_eff(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-and-find-first: first set request after the pointer, wrapping.
module rr_pick
  import wrr_pkg::*;
#(
  parameter int CLIENTS = 8,
  localparam int ID_W = id_width(CLIENTS)
) (
  input  logic [CLIENTS-1:0] i_request,
  input  logic [ID_W-1:0]    i_pointer,
  output logic               o_found,
  output logic [CLIENTS-1:0] o_onehot,
  output logic [ID_W-1:0]    o_index
);

  int unsigned w_cand;

  // The pointer position itself is visited last, so it loses to every other requester.
  always_comb begin
    o_found  = 1'b0;
    o_index  = '0;
    o_onehot = '0;
    w_cand   = 0;
    for (int k = 1; k <= CLIENTS; k++) begin
      w_cand = (int'(i_pointer) + k) % CLIENTS;
      if (!o_found && i_request[w_cand[ID_W-1:0]]) begin
        o_found = 1'b1;
        o_index = w_cand[ID_W-1:0];
      end
    end
    if (o_found) o_onehot = CLIENTS'(1) << o_index;
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: a granted client keeps the resource for up to
// its latched weight in consecutive cycles before the grant rotates.
module wrr_arbiter
  import wrr_pkg::*;
#(
  parameter int CLIENTS  = 8,
  parameter int WEIGHT_W = 4,
  localparam int ID_W    = id_width(CLIENTS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CLIENTS-1:0]           request,
  input  logic [CLIENTS*WEIGHT_W-1:0]  weight,
  input  logic                         stall,
  output logic [CLIENTS-1:0]           grant,
  output logic [ID_W-1:0]              grant_id,
  output logic                         burst_last
);

  state_t               r_state;
  logic [CLIENTS-1:0]   r_grant;
  logic [ID_W-1:0]      r_grantId;
  logic [ID_W-1:0]      r_ptr;
  logic [WEIGHT_W:0]    r_count;
  logic [WEIGHT_W:0]    r_limit;

  logic                 w_found;
  logic [CLIENTS-1:0]   w_pickOnehot;
  logic [ID_W-1:0]      w_pickIdx;
  logic [ID_W-1:0]      w_pickPtr;
  logic                 w_continue;
  logic [WEIGHT_W-1:0]  w_pickWeight;

  // While holding, the search starts just past the current owner so it is considered last.
  assign w_pickPtr    = (r_state == HOLD) ? r_grantId : r_ptr;
  assign w_continue   = (r_state == HOLD) && request[r_grantId] && (r_count < r_limit);
  assign w_pickWeight = weight[int'(w_pickIdx)*WEIGHT_W +: WEIGHT_W];

  rr_pick #(
    .CLIENTS (CLIENTS)
  ) u_pick (
    .i_request (request),
    .i_pointer (w_pickPtr),
    .o_found   (w_found),
    .o_onehot  (w_pickOnehot),
    .o_index   (w_pickIdx)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_grantId <= '0;
      r_ptr     <= ID_W'(CLIENTS - 1);
      r_count   <= '0;
      r_limit   <= '0;
    end else if (!stall) begin
      if (w_continue) begin
        r_count <= r_count + (WEIGHT_W+1)'(1);
      end else begin
        if (r_state == HOLD) r_ptr <= r_grantId;
        if (w_found) begin
          r_state   <= HOLD;
          r_grant   <= w_pickOnehot;
          r_grantId <= w_pickIdx;
          r_count   <= (WEIGHT_W+1)'(1);
          r_limit   <= (WEIGHT_W+1)'(weight_eff(int'(w_pickWeight)));
        end else begin
          r_state   <= IDLE;
          r_grant   <= '0;
          r_grantId <= '0;
          r_count   <= '0;
        end
      end
    end
  end

  assign grant      = r_grant;
  assign grant_id   = r_grantId;
  assign burst_last = (r_state == HOLD) && (r_count == r_limit);

endmodule

// File: tb/tb_wrr_arbiter.sv
// Scoreboard bench for wrr_arbiter: directed scenarios with hand-derived
// expectations, then random traffic checked against a behavioural model.
module tb_wrr_arbiter;

  localparam int CLIENTS  = 8;
  localparam int WEIGHT_W = 4;
  localparam int ID_W     = 3;

  logic                        clock;
  logic                        reset;
  logic [CLIENTS-1:0]          request;
  logic [CLIENTS*WEIGHT_W-1:0] weight;
  logic                        stall;
  logic [CLIENTS-1:0]          grant;
  logic [ID_W-1:0]             grant_id;
  logic                        burst_last;

  typedef struct {
    logic [CLIENTS-1:0] grant;
    logic [ID_W-1:0]    id;
    logic               last;
    string              tag;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  // Model state: who holds the resource, how many cycles used, its allowance, pointer.
  int mHolder = -1;
  int mUsed   = 0;
  int mLimit  = 0;
  int mPtr    = CLIENTS - 1;

  wrr_arbiter #(
    .CLIENTS  (CLIENTS),
    .WEIGHT_W (WEIGHT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .request    (request),
    .weight     (weight),
    .stall      (stall),
    .grant      (grant),
    .grant_id   (grant_id),
    .burst_last (burst_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [ID_W-1:0] idOf(input logic [CLIENTS-1:0] g);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < CLIENTS; i++) if (g[i]) r = ID_W'(i);
    return r;
  endfunction

  task automatic modelStep(input logic [CLIENTS-1:0] req, input logic [CLIENTS*WEIGHT_W-1:0] wt,
                           input logic st, input logic rs);
    int c;
    int w;
    if (!rs) begin
      mHolder = -1; mUsed = 0; mLimit = 0; mPtr = CLIENTS - 1;
    end else if (!st) begin
      if (mHolder >= 0 && req[mHolder] && mUsed < mLimit) begin
        mUsed++;
      end else begin
        if (mHolder >= 0) mPtr = mHolder;
        mHolder = -1;
        mUsed = 0;
        for (int k = 1; k <= CLIENTS; k++) begin
          c = (mPtr + k) % CLIENTS;
          if (mHolder < 0 && req[c]) begin
            w = int'(wt[c*WEIGHT_W +: WEIGHT_W]);
            mHolder = c;
            mUsed = 1;
            mLimit = (w == 0) ? 1 : w;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, and queue what the DUT must show after the edge.
  task automatic applyStimulus(input logic [CLIENTS-1:0] req, input logic [CLIENTS*WEIGHT_W-1:0] wt,
                               input logic st, input logic rs, input logic directed,
                               input logic [CLIENTS-1:0] expGrant, input logic expLast, input string tag);
    exp_t e;
    @(negedge clock);
    request = req;
    weight  = wt;
    stall   = st;
    reset   = rs;
    modelStep(req, wt, st, rs);
    e.tag = tag;
    if (directed) begin
      e.grant = expGrant;
      e.id    = idOf(expGrant);
      e.last  = expLast;
    end else begin
      e.grant = (mHolder >= 0) ? (CLIENTS'(1) << mHolder) : '0;
      e.id    = (mHolder >= 0) ? ID_W'(mHolder) : '0;
      e.last  = (mHolder >= 0) && (mUsed == mLimit);
    end
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    testsRun++;
    if (actual !== required) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Monitor pops one expectation per edge once stimulus has queued it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.tag, ".grant"}, 32'(grant), 32'(e.grant));
        checkOutput({e.tag, ".grant_id"}, 32'(grant_id), 32'(e.id));
        checkOutput({e.tag, ".burst_last"}, 32'(burst_last), 32'(e.last));
        checkOutput({e.tag, ".onehot0"}, 32'($onehot0(grant)), 32'd1);
      end
    end
  end

  localparam logic [31:0] W_ALL1 = 32'h1111_1111;

  initial begin
    logic [CLIENTS-1:0]          rReq;
    logic [CLIENTS*WEIGHT_W-1:0] rWt;
    logic                        rSt;
    logic                        rRs;
    int                          waitCycles;
    request = '0; weight = W_ALL1; stall = 1'b0; reset = 1'b0;

    applyStimulus(8'h00, W_ALL1, 0, 0, 1, 8'h00, 0, "reset0");
    applyStimulus(8'h00, W_ALL1, 0, 0, 1, 8'h00, 0, "reset1");

    for (int i = 0; i < 4; i++)
      applyStimulus(8'h81, W_ALL1, 0, 1, 1, (i % 2 == 0) ? 8'h01 : 8'h80, 1, "prio");

    for (int i = 0; i < 12; i++)
      applyStimulus(8'h06, 32'h1111_1131, 0, 1, 1, (i % 4 == 3) ? 8'h04 : 8'h02,
                    (i % 4 >= 2), "weighted");

    applyStimulus(8'h00, 32'h1111_5111, 0, 1, 1, 8'h00, 0, "dropIdle");
    applyStimulus(8'h08, 32'h1111_5111, 0, 1, 1, 8'h08, 0, "dropG1");
    applyStimulus(8'h28, 32'h1111_5111, 0, 1, 1, 8'h08, 0, "dropG2");
    applyStimulus(8'h20, 32'h1111_5111, 0, 1, 1, 8'h20, 1, "dropMove");
    applyStimulus(8'h00, 32'h1111_5111, 0, 1, 1, 8'h00, 0, "dropEnd");

    for (int i = 0; i < 4; i++)
      applyStimulus(8'h10, 32'h1110_1111, 0, 1, 1, 8'h10, 1, "zeroW");

    applyStimulus(8'h00, 32'h1111_1411, 0, 1, 1, 8'h00, 0, "stallIdle");
    applyStimulus(8'h04, 32'h1111_1411, 0, 1, 1, 8'h04, 0, "stallC1");
    applyStimulus(8'h04, 32'h1111_1411, 0, 1, 1, 8'h04, 0, "stallC2");
    for (int i = 0; i < 4; i++)
      applyStimulus(8'h05, 32'h1111_1411, 1, 1, 1, 8'h04, 0, "stallHold");
    applyStimulus(8'h05, 32'h1111_1411, 0, 1, 1, 8'h04, 0, "stallC3");
    applyStimulus(8'h05, 32'h1111_1411, 0, 1, 1, 8'h04, 1, "stallC4");
    applyStimulus(8'h05, 32'h1111_1411, 0, 1, 1, 8'h01, 1, "stallNext");

    applyStimulus(8'h00, W_ALL1, 0, 1, 1, 8'h00, 0, "rstIdle");
    applyStimulus(8'h40, W_ALL1, 0, 1, 1, 8'h40, 1, "rstG6");
    applyStimulus(8'h40, W_ALL1, 1, 0, 1, 8'h00, 0, "rstMid");
    applyStimulus(8'hFF, W_ALL1, 0, 1, 1, 8'h01, 1, "rstPrio");
    applyStimulus(8'hFF, W_ALL1, 0, 1, 1, 8'h02, 1, "rstNext");

    for (int i = 0; i < 600; i++) begin
      rReq = CLIENTS'($urandom);
      rWt  = $urandom;
      rSt  = ($urandom_range(0, 99) < 15);
      rRs  = ($urandom_range(0, 99) >= 2);
      applyStimulus(rReq, rWt, rSt, rRs, 0, 8'h00, 0, "random");
    end

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(posedge clock);
      waitCycles++;
    end
    #2;
    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
